// File: rtl/cpu_step_ctrl.sv
// Run/halt/single-step controller: debounces STEP and RUN buttons on a strobe
// derived from clk_d and produces a glitch-free clock-enable for the core.
`timescale 1ns/1ps
module cpu_step_ctrl #(
  parameter int DEB_CNT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_d,
  input  logic             btn_step,
  input  logic             btn_run,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] step_count,
  output logic             sample_tick
);

  // state | meaning
  // HALT  | core stopped, waiting for a RUN or STEP press
  // STEP  | single enable cycle, always returns to HALT
  // RUN   | core enabled continuously until halt_req or RUN press
  localparam logic [2:0] S_HALT = 3'b001;
  localparam logic [2:0] S_STEP = 3'b010;
  localparam logic [2:0] S_RUN  = 3'b100;

  localparam logic [3:0] DEB_LAST = 4'(DEB_CNT - 1);

  logic             r_clkd_s1, r_clkd_s2, r_clkd_dly, r_tick;
  logic [1:0]       r_btn_s1, r_btn_s2;
  logic [1:0]       r_deb, r_deb_q, r_press;
  logic [3:0]       r_deb_cnt [2];
  logic [2:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_step_cnt;
  logic             w_step_press, w_run_press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clkd_s1  <= 1'b0;
      r_clkd_s2  <= 1'b0;
      r_clkd_dly <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_clkd_s1  <= clk_d;
      r_clkd_s2  <= r_clkd_s1;
      r_clkd_dly <= r_clkd_s2;
      r_tick     <= r_clkd_s2 & ~r_clkd_dly;
    end
  end

  // Bit 0 is STEP, bit 1 is RUN; both buttons share the same debounce logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_s1     <= 2'b00;
      r_btn_s2     <= 2'b00;
      r_deb        <= 2'b00;
      r_deb_q      <= 2'b00;
      r_press      <= 2'b00;
      r_deb_cnt[0] <= 4'd0;
      r_deb_cnt[1] <= 4'd0;
    end else begin
      r_btn_s1 <= {btn_run, btn_step};
      r_btn_s2 <= r_btn_s1;
      r_deb_q  <= r_deb;
      r_press  <= r_deb & ~r_deb_q;
      if (r_tick) begin
        for (int i = 0; i < 2; i++) begin
          if (r_btn_s2[i] != r_deb[i]) begin
            if (r_deb_cnt[i] == DEB_LAST) begin
              r_deb[i]     <= ~r_deb[i];
              r_deb_cnt[i] <= 4'd0;
            end else begin
              r_deb_cnt[i] <= r_deb_cnt[i] + 4'd1;
            end
          end else begin
            r_deb_cnt[i] <= 4'd0;
          end
        end
      end
    end
  end

  assign w_step_press = r_press[0];
  assign w_run_press  = r_press[1];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HALT: begin
        if (w_run_press)       w_state_nxt = S_RUN;
        else if (w_step_press) w_state_nxt = S_STEP;
      end
      S_STEP: w_state_nxt = S_HALT;
      S_RUN: begin
        if (halt_req || w_run_press) w_state_nxt = S_HALT;
      end
      default: w_state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_HALT;
    else       r_state <= w_state_nxt;
  end

  // One-hot state: every output is a single flop bit, so no decode glitches.
  assign cpu_en  = ~r_state[0];
  assign running = r_state[2];
  assign halted  = r_state[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_step_cnt <= '0;
    else if (cpu_en) r_step_cnt <= r_step_cnt + CNT_W'(1);
  end

  assign step_count  = r_step_cnt;
  assign sample_tick = r_tick;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl: vector table of button patterns plus
// hand sequences for strobe latency, RUN timing, halt_req, reset and wrap.
`timescale 1ns/1ps
module tb_cpu_step_ctrl;

  logic        clk = 1'b0, reset = 1'b1, clk_d = 1'b0;
  logic        btn_step = 1'b0, btn_run = 1'b0, halt_req = 1'b0;
  logic        cpu_en, running, halted, sample_tick;
  logic [15:0] step_count;
  logic        cpu_en4, running4, halted4, sample_tick4;
  logic [3:0]  step_count4;

  int clkd_half = 100;
  int n_vec = 0, n_err = 0;
  int mon_en = 0;

  cpu_step_ctrl #(.DEB_CNT(4), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .clk_d(clk_d), .btn_step(btn_step), .btn_run(btn_run),
    .halt_req(halt_req), .cpu_en(cpu_en), .running(running), .halted(halted),
    .step_count(step_count), .sample_tick(sample_tick));

  cpu_step_ctrl #(.DEB_CNT(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .clk_d(clk_d), .btn_step(btn_step), .btn_run(btn_run),
    .halt_req(halt_req), .cpu_en(cpu_en4), .running(running4), .halted(halted4),
    .step_count(step_count4), .sample_tick(sample_tick4));

  always #5 clk = ~clk;
  initial forever #(clkd_half * 10) clk_d = ~clk_d;

  // Independent count of enabled cycles, as seen on cpu_en.
  always @(posedge clk or posedge reset) begin
    if (reset)       mon_en <= 0;
    else if (cpu_en) mon_en <= mon_en + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int step_hi;
    int run_hi;
    bit bounce;
    int exp_en;
    bit exp_run;
    bit exp_halt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Returns 50 ns after a clk_d rise, clear of that sample's decision.
  task automatic next_sample();
    @(posedge clk_d);
    #50;
  endtask

  task automatic press(input bit st, input bit rn, input int n);
    next_sample();
    for (int i = 0; i < n; i++) begin
      btn_step = st;
      btn_run  = rn;
      next_sample();
    end
    btn_step = 1'b0;
    btn_run  = 1'b0;
    repeat (6) next_sample();
  endtask

  task automatic wait_running(input bit want, input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (running == want) break;
    end
    chk(nm, int'(running), int'(want));
  endtask

  task automatic apply_vec(input vec_t v, input int k);
    int en0, n, reps;
    en0  = mon_en;
    reps = v.bounce ? 2 : 1;
    n    = (v.step_hi > v.run_hi) ? v.step_hi : v.run_hi;
    next_sample();
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < n; i++) begin
        btn_step = (i < v.step_hi);
        btn_run  = (i < v.run_hi);
        next_sample();
      end
      btn_step = 1'b0;
      btn_run  = 1'b0;
      if (r < reps - 1) next_sample();
    end
    repeat (6) next_sample();
    @(negedge clk);
    if (v.exp_en >= 0) chk($sformatf("vec%0d en_cycles", k), mon_en - en0, v.exp_en);
    chk($sformatf("vec%0d running", k), int'(running), int'(v.exp_run));
    chk($sformatf("vec%0d halted", k), int'(halted), int'(v.exp_halt));
    chk($sformatf("vec%0d step_count", k), int'(step_count), mon_en);
    chk($sformatf("vec%0d step_count4", k), int'(step_count4), mon_en % 16);
  endtask

  initial begin
    int ticks, base, en0;
    vecs[0] = '{6, 0, 1'b0,  1, 1'b0, 1'b1};
    vecs[1] = '{6, 0, 1'b0,  1, 1'b0, 1'b1};
    vecs[2] = '{6, 0, 1'b0,  1, 1'b0, 1'b1};
    vecs[3] = '{3, 0, 1'b1,  0, 1'b0, 1'b1};
    vecs[4] = '{2, 0, 1'b0,  0, 1'b0, 1'b1};
    vecs[5] = '{5, 5, 1'b0, -1, 1'b1, 1'b0};
    vecs[6] = '{6, 0, 1'b0, -1, 1'b1, 1'b0};
    vecs[7] = '{0, 5, 1'b0, -1, 1'b0, 1'b1};

    // Reset state and strobe latency
    repeat (3) @(negedge clk);
    chk("rst halted", int'(halted), 1);
    chk("rst running", int'(running), 0);
    chk("rst cpu_en", int'(cpu_en), 0);
    chk("rst step_count", int'(step_count), 0);
    chk("rst sample_tick", int'(sample_tick), 0);
    reset = 1'b0;
    @(posedge clk_d);
    repeat (2) @(negedge clk);
    chk("tick lat2", int'(sample_tick), 0);
    @(negedge clk);
    chk("tick lat3", int'(sample_tick), 1);
    @(negedge clk);
    chk("tick width", int'(sample_tick), 0);
    @(negedge clk_d);
    repeat (5) @(negedge clk);
    chk("tick on fall", int'(sample_tick), 0);
    ticks = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (sample_tick) ticks++;
    end
    chk("idle ticks", ticks, 10);
    chk("idle halted", int'(halted), 1);
    chk("idle cpu_en", int'(cpu_en), 0);
    chk("idle step_count", int'(step_count), 0);

    // Table vectors
    for (int k = 0; k < 8; k++) begin
      apply_vec(vecs[k], k);
      if (k == 4) chk("three steps", int'(step_count), 3);
    end

    // RUN for exactly 500 cycles, then a 1-cycle halt_req
    next_sample();
    btn_run = 1'b1;
    wait_running(1'b1, 3000, "run entered");
    base = mon_en;
    repeat (499) @(negedge clk);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    chk("halt_req halted", int'(halted), 1);
    chk("run 500 count", int'(step_count), base + 500);
    btn_run = 1'b0;
    repeat (6) next_sample();
    chk("count frozen", int'(step_count), base + 500);

    // RUN re-entered with halt_req held high lasts one cycle
    halt_req = 1'b1;
    en0 = mon_en;
    press(1'b0, 1'b1, 5);
    @(negedge clk);
    chk("hreq one run cycle", mon_en - en0, 1);
    chk("hreq halted", int'(halted), 1);
    halt_req = 1'b0;

    // Reset mid-RUN, button held through reset
    next_sample();
    btn_run = 1'b1;
    wait_running(1'b1, 3000, "run before reset");
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async rst cpu_en", int'(cpu_en), 0);
    chk("async rst halted", int'(halted), 1);
    chk("async rst count", int'(step_count), 0);
    chk("async rst count4", int'(step_count4), 0);
    @(negedge clk_d);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk_d);
    #100;
    chk("held run 3 samples", int'(running), 0);
    @(posedge clk_d);
    #100;
    chk("held run 4 samples", int'(running), 1);
    btn_run = 1'b0;
    repeat (6) next_sample();
    press(1'b0, 1'b1, 5);
    @(negedge clk);
    chk("held run halted", int'(halted), 1);

    // Wrap of the 4-bit counter after 17 steps, with a faster sample clock
    clkd_half = 10;
    repeat (3) @(negedge clk_d);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) press(1'b1, 1'b0, 6);
    @(negedge clk);
    chk("17 steps count16", int'(step_count), 17);
    chk("17 steps count4 wrap", int'(step_count4), 1);
    chk("17 steps halted", int'(halted), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
